// File: rtl/loom_clk_ctrl.sv
// Run/stop/step clock-enable controller for the emulated-domain clock gate.
// Optional emulated-cycle counter enabled by defining LOOM_CLK_CTRL_CYCLE_CNT_EN.
module loom_clk_ctrl #(
    parameter int unsigned STEP_W        = 32,
    parameter int unsigned CYC_W         = 64,
    parameter bit          START_RUNNING = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    input  logic [1:0]        cmd_i,
    input  logic [STEP_W-1:0] cmd_step_i,
    input  logic              trig_stop_i,
    output logic              ce_o,
    output logic [1:0]        state_o,
    output logic [STEP_W-1:0] steps_left_o,
    output logic [1:0]        stop_cause_o,
    output logic              stop_evt_o,
    output logic              cmd_err_o,
    output logic [CYC_W-1:0]  cycle_cnt_o
);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_RUN     = 2'b01,
        ST_STEP    = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STOP = 2'b10,
        CMD_STEP = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_HOST = 2'b01,
        CAUSE_TRIG = 2'b10,
        CAUSE_STEP = 2'b11
    } cause_e;

    localparam state_e RST_STATE = START_RUNNING ? ST_RUN : ST_STOPPED;
    localparam logic   RST_CE    = START_RUNNING;

    state_e            state_q, state_d;
    logic              ce_q, ce_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    cause_e            cause_q, cause_d;
    logic              evt_q, evt_d;
    logic              err_q, err_d;

    cmd_e cmd;
    logic is_run, is_stop, is_step;

    assign cmd     = cmd_e'(cmd_i);
    assign is_run  = cmd_valid_i && (cmd == CMD_RUN);
    assign is_stop = cmd_valid_i && (cmd == CMD_STOP);
    assign is_step = cmd_valid_i && (cmd == CMD_STEP);

    always_comb begin
        cause_e stop_why;
        // NOTE: every _d gets a default before any branch, so no path can infer a latch.
        state_d  = state_q;
        ce_d     = ce_q;
        steps_d  = steps_q;
        cause_d  = cause_q;
        evt_d    = 1'b0;
        err_d    = is_step && (state_q != ST_STOPPED);
        stop_why = CAUSE_NONE;

        // Trigger beats step completion, which beats a host STOP.
        if ((state_q != ST_STOPPED) && trig_stop_i) begin
            stop_why = CAUSE_TRIG;
        end else if ((state_q == ST_STEP) && (steps_q == STEP_W'(1))) begin
            stop_why = CAUSE_STEP;
        end else if ((state_q != ST_STOPPED) && is_stop) begin
            stop_why = CAUSE_HOST;
        end

        if (stop_why != CAUSE_NONE) begin
            state_d = ST_STOPPED;
            ce_d    = 1'b0;
            steps_d = '0;
            cause_d = stop_why;
            evt_d   = 1'b1;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    if (is_run) begin
                        state_d = ST_RUN;
                        ce_d    = 1'b1;
                    end else if (is_step && (cmd_step_i != '0)) begin
                        state_d = ST_STEP;
                        ce_d    = 1'b1;
                        steps_d = cmd_step_i;
                    end
                end
                ST_RUN: begin
                end
                ST_STEP: begin
                    if (is_run) begin
                        state_d = ST_RUN;
                        steps_d = '0;
                    end else begin
                        steps_d = steps_q - STEP_W'(1);
                    end
                end
                default: begin
                    state_d = ST_STOPPED;
                    ce_d    = 1'b0;
                    steps_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= RST_STATE;
            ce_q    <= RST_CE;
            steps_q <= '0;
            cause_q <= CAUSE_NONE;
            evt_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            steps_q <= steps_d;
            cause_q <= cause_d;
            evt_q   <= evt_d;
            err_q   <= err_d;
        end
    end

    assign ce_o         = ce_q;
    assign state_o      = state_q;
    assign steps_left_o = steps_q;
    assign stop_cause_o = cause_q;
    assign stop_evt_o   = evt_q;
    assign cmd_err_o    = err_q;

`ifdef LOOM_CLK_CTRL_CYCLE_CNT_EN
    logic [CYC_W-1:0] cyc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= '0;
        end else if (ce_q) begin
            cyc_q <= cyc_q + CYC_W'(1);
        end
    end

    assign cycle_cnt_o = cyc_q;
`else
    assign cycle_cnt_o = '0;
`endif

endmodule

// File: tb/tb_loom_clk_ctrl.sv
// Self-checking bench for loom_clk_ctrl: directed vector table, corner sequences,
// and random traffic against a behavioural mode/target/done reference model.
module tb_loom_clk_ctrl;

    localparam int STEP_W = 8;
    localparam int CYC_W  = 4;

    localparam int CMD_NOP  = 0;
    localparam int CMD_RUN  = 1;
    localparam int CMD_STOP = 2;
    localparam int CMD_STEP = 3;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic [STEP_W-1:0] cmd_step;
    logic              trig;

    logic              ce_o, ce0_o;
    logic [1:0]        state_o, state0_o;
    logic [STEP_W-1:0] left_o, left0_o;
    logic [1:0]        cause_o, cause0_o;
    logic              evt_o, evt0_o;
    logic              err_o, err0_o;
    logic [CYC_W-1:0]  cyc_o, cyc0_o;

    loom_clk_ctrl #(.STEP_W(STEP_W), .CYC_W(CYC_W), .START_RUNNING(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_i(cmd),
        .cmd_step_i(cmd_step), .trig_stop_i(trig), .ce_o(ce_o), .state_o(state_o),
        .steps_left_o(left_o), .stop_cause_o(cause_o), .stop_evt_o(evt_o),
        .cmd_err_o(err_o), .cycle_cnt_o(cyc_o)
    );

    loom_clk_ctrl #(.STEP_W(STEP_W), .CYC_W(CYC_W), .START_RUNNING(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_i(cmd),
        .cmd_step_i(cmd_step), .trig_stop_i(trig), .ce_o(ce0_o), .state_o(state0_o),
        .steps_left_o(left0_o), .stop_cause_o(cause0_o), .stop_evt_o(evt0_o),
        .cmd_err_o(err0_o), .cycle_cnt_o(cyc0_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 stopped, 1 running, 2 stepping; ce is simply "not stopped".
    int     m_mode;
    int     m_target;
    int     m_done;
    int     m_cause;
    bit     m_evt;
    bit     m_err;
    longint m_cyc;

    task automatic model_reset();
        m_mode = 1; m_target = 0; m_done = 0; m_cause = 0;
        m_evt = 0; m_err = 0; m_cyc = 0;
    endtask

    task automatic model_edge(input int v, input int c, input int n, input int t);
        int why;
        bit run_c, stop_c, step_c;
        run_c  = (v != 0) && (c == CMD_RUN);
        stop_c = (v != 0) && (c == CMD_STOP);
        step_c = (v != 0) && (c == CMD_STEP);
        m_err  = step_c && (m_mode != 0);
        if (m_mode != 0) m_cyc = (m_cyc + 1) % (longint'(1) << CYC_W);
        why = 0;
        if (m_mode != 0 && t != 0)                        why = 2;
        else if (m_mode == 2 && m_target - m_done == 1)   why = 3;
        else if (m_mode != 0 && stop_c)                   why = 1;
        m_evt = (why != 0);
        if (why != 0) begin
            m_mode = 0;
            m_cause = why;
        end else if (m_mode == 0) begin
            if (run_c) m_mode = 1;
            else if (step_c && n != 0) begin
                m_mode = 2; m_target = n; m_done = 0;
            end
        end else if (m_mode == 2) begin
            if (run_c) m_mode = 1;
            else m_done++;
        end
    endtask

    function automatic longint exp_cyc();
`ifdef LOOM_CLK_CTRL_CYCLE_CNT_EN
        return m_cyc;
`else
        return 0;
`endif
    endfunction

    task automatic compare_model(input string tag);
        check({tag, ".ce"},    64'(ce_o),    64'(m_mode != 0));
        check({tag, ".state"}, 64'(state_o), 64'(m_mode));
        check({tag, ".left"},  64'(left_o),  64'((m_mode == 2) ? (m_target - m_done) : 0));
        check({tag, ".cause"}, 64'(cause_o), 64'(m_cause));
        check({tag, ".evt"},   64'(evt_o),   64'(m_evt));
        check({tag, ".err"},   64'(err_o),   64'(m_err));
        check({tag, ".cyc"},   64'(cyc_o),   64'(exp_cyc()));
    endtask

    task automatic tick(input int v, input int c, input int n, input int t);
        cmd_valid = 1'(v);
        cmd       = 2'(c);
        cmd_step  = STEP_W'(n);
        trig      = 1'(t);
        @(posedge clk);
        model_edge(v, c, n, t);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; cmd = 2'd0; cmd_step = '0; trig = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic              v;
        logic [1:0]        c;
        logic [STEP_W-1:0] n;
        logic              t;
        logic              ce;
        logic [1:0]        st;
        logic [STEP_W-1:0] left;
        logic [1:0]        cause;
        logic              evt;
        logic              err;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int v, input int c, input int n, input int t, input int ce,
                           input int st, input int left, input int cause, input int evt, input int err);
        vec_t r;
        r.v = 1'(v); r.c = 2'(c); r.n = STEP_W'(n); r.t = 1'(t);
        r.ce = 1'(ce); r.st = 2'(st); r.left = STEP_W'(left);
        r.cause = 2'(cause); r.evt = 1'(evt); r.err = 1'(err);
        vq.push_back(r);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int en;
        int evts;
        int base;

        //      v  cmd       n    t  ce st left cause evt err
        add_vec(0, CMD_NOP,  0,   0, 1, 1, 0,   0,    0,  0);
        add_vec(1, CMD_STEP, 3,   0, 1, 1, 0,   0,    0,  1);  // STEP in RUN is illegal
        add_vec(0, CMD_NOP,  0,   0, 1, 1, 0,   0,    0,  0);
        add_vec(1, CMD_STOP, 0,   0, 0, 0, 0,   1,    1,  0);
        add_vec(0, CMD_NOP,  0,   0, 0, 0, 0,   1,    0,  0);
        add_vec(1, CMD_STOP, 0,   0, 0, 0, 0,   1,    0,  0);
        add_vec(0, CMD_NOP,  0,   1, 0, 0, 0,   1,    0,  0);  // trigger ignored while stopped
        add_vec(1, CMD_STEP, 0,   0, 0, 0, 0,   1,    0,  0);  // STEP 0 does nothing
        add_vec(1, CMD_STEP, 3,   0, 1, 2, 3,   1,    0,  0);
        add_vec(0, CMD_NOP,  0,   0, 1, 2, 2,   1,    0,  0);
        add_vec(0, CMD_NOP,  0,   0, 1, 2, 1,   1,    0,  0);
        add_vec(0, CMD_NOP,  0,   0, 0, 0, 0,   3,    1,  0);
        add_vec(1, CMD_RUN,  0,   0, 1, 1, 0,   3,    0,  0);
        add_vec(1, CMD_STOP, 0,   1, 0, 0, 0,   2,    1,  0);  // trigger beats STOP
        add_vec(1, CMD_STEP, 2,   0, 1, 2, 2,   2,    0,  0);
        add_vec(0, CMD_NOP,  0,   0, 1, 2, 1,   2,    0,  0);
        add_vec(0, CMD_NOP,  0,   1, 0, 0, 0,   2,    1,  0);  // trigger beats last step
        add_vec(1, CMD_STEP, 5,   0, 1, 2, 5,   2,    0,  0);
        add_vec(1, CMD_RUN,  0,   0, 1, 1, 0,   2,    0,  0);
        add_vec(1, CMD_STOP, 0,   0, 0, 0, 0,   1,    1,  0);
        add_vec(1, CMD_STEP, 4,   0, 1, 2, 4,   1,    0,  0);
        add_vec(1, CMD_STEP, 7,   0, 1, 2, 3,   1,    0,  1);  // STEP in STEP is illegal
        add_vec(1, CMD_STOP, 0,   0, 0, 0, 0,   1,    1,  0);

        do_reset();
        check("rst.ce",     64'(ce_o),     64'd1);
        check("rst.state",  64'(state_o),  64'd1);
        check("rst.left",   64'(left_o),   64'd0);
        check("rst.cause",  64'(cause_o),  64'd0);
        check("rst.evt",    64'(evt_o),    64'd0);
        check("rst.err",    64'(err_o),    64'd0);
        check("rst.cyc",    64'(cyc_o),    64'd0);
        check("rst0.ce",    64'(ce0_o),    64'd0);
        check("rst0.state", 64'(state0_o), 64'd0);

        foreach (vq[i]) begin
            tick(int'(vq[i].v), int'(vq[i].c), int'(vq[i].n), int'(vq[i].t));
            check($sformatf("vec%0d.ce", i),    64'(ce_o),    64'(vq[i].ce));
            check($sformatf("vec%0d.state", i), 64'(state_o), 64'(vq[i].st));
            check($sformatf("vec%0d.left", i),  64'(left_o),  64'(vq[i].left));
            check($sformatf("vec%0d.cause", i), 64'(cause_o), 64'(vq[i].cause));
            check($sformatf("vec%0d.evt", i),   64'(evt_o),   64'(vq[i].evt));
            check($sformatf("vec%0d.err", i),   64'(err_o),   64'(vq[i].err));
            check($sformatf("vec%0d.cyc", i),   64'(cyc_o),   64'(exp_cyc()));
        end

        // STEP 5: exactly five enabled cycles counting 5..1, one event, cause step-done.
        tick(1, CMD_STEP, 5, 0);
        compare_model("step5.entry");
        en = 0; evts = 0;
        for (int i = 0; i < 12; i++) begin
            if (ce_o) begin
                check("step5.left_seq", 64'(left_o), 64'(5 - en));
                en++;
            end
            tick(0, CMD_NOP, 0, 0);
            compare_model("step5");
            if (evt_o) evts++;
        end
        check("step5.enabled_cycles", 64'(en), 64'd5);
        check("step5.events", 64'(evts), 64'd1);
        check("step5.cause", 64'(cause_o), 64'd3);

        tick(1, CMD_STEP, 0, 0);
        check("step0.ce", 64'(ce_o), 64'd0);
        check("step0.evt", 64'(evt_o), 64'd0);

        // STEP 100 with the trigger raised in the third enabled cycle.
        tick(1, CMD_STEP, 100, 0);
        en = 0;
        for (int i = 0; i < 10; i++) begin
            if (ce_o) en++;
            tick(0, CMD_NOP, 0, (ce_o && en == 3) ? 1 : 0);
            compare_model("step100");
        end
        check("step100.enabled_cycles", 64'(en), 64'd3);
        check("step100.left", 64'(left_o), 64'd0);
        check("step100.cause", 64'(cause_o), 64'd2);

        // Largest legal count must run its full length without wrapping.
        tick(1, CMD_STEP, (1 << STEP_W) - 1, 0);
        check("stepmax.left", 64'(left_o), 64'((1 << STEP_W) - 1));
        en = 0;
        for (int i = 0; i < 300; i++) begin
            if (ce_o) en++;
            tick(0, CMD_NOP, 0, 0);
            compare_model("stepmax");
        end
        check("stepmax.enabled_cycles", 64'(en), 64'((1 << STEP_W) - 1));
        check("stepmax.cause", 64'(cause_o), 64'd3);

        // Cycle counter wraps after 17 enabled cycles from reset.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            tick(0, CMD_NOP, 0, 0);
            compare_model("wrap");
        end
`ifdef LOOM_CLK_CTRL_CYCLE_CNT_EN
        check("wrap.cyc", 64'(cyc_o), 64'd1);
`else
        check("wrap.cyc", 64'(cyc_o), 64'd0);
`endif

        // Asynchronous reset in the middle of a STEP.
        tick(1, CMD_STOP, 0, 0);
        tick(1, CMD_STEP, 10, 0);
        tick(0, CMD_NOP, 0, 0);
        tick(0, CMD_NOP, 0, 0);
        compare_model("prereset");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.ce",    64'(ce_o),    64'd1);
        check("midrst.state", 64'(state_o), 64'd1);
        check("midrst.left",  64'(left_o),  64'd0);
        check("midrst.cause", 64'(cause_o), 64'd0);
        check("midrst.cyc",   64'(cyc_o),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Random traffic against the reference model.
        base = 0;
        for (int i = 0; i < 600; i++) begin
            int v, c, n, t;
            v = ($urandom_range(0, 9) < 6) ? 1 : 0;
            c = $urandom_range(0, 3);
            n = ($urandom_range(0, 19) == 0) ? $urandom_range(0, (1 << STEP_W) - 1)
                                             : $urandom_range(0, 6);
            t = ($urandom_range(0, 19) == 0) ? 1 : 0;
            tick(v, c, n, t);
            compare_model("rand");
            base++;
        end
        check("rand.iterations", 64'(base), 64'd600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loom_clk_ctrl.md
Name: loom_clk_ctrl

Overview:
- Run/stop/step controller that produces the registered clock-enable consumed by the downstream glitch-free clock gate.
- Accepts host commands (RUN, STOP, STEP N) and a DUT-side trigger stop.
- Guarantees an exact count of enabled cycles in STEP mode and reports stop cause and status.
- Sits between the host control/CSR block and the clock gating cell of the emulated domain.

Parameters:
- STEP_W, 32, width of step count and steps-remaining counter
- CYC_W, 64, width of emulated-cycle counter (optional feature)
- START_RUNNING, 1, 1 = leave reset in RUN with ce_o=1; 0 = leave reset in STOPPED with ce_o=0

Ports:
- clk_i  in  1  free-running clock; single clock domain
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command strobe, one command per cycle, always accepted
- cmd_i  in  2  00 NOP, 01 RUN, 10 STOP, 11 STEP
- cmd_step_i  in  STEP_W  step count N, sampled with STEP
- trig_stop_i  in  1  DUT breakpoint/trigger, level, sampled each cycle
- ce_o  out  1  registered clock enable to the gate; 1 = run
- state_o  out  2  00 STOPPED, 01 RUN, 10 STEP
- steps_left_o  out  STEP_W  remaining enabled cycles in STEP
- stop_cause_o  out  2  00 none/reset, 01 host STOP, 10 trigger, 11 step done
- stop_evt_o  out  1  one-cycle pulse on every entry to STOPPED
- cmd_err_o  out  1  one-cycle pulse on an illegal command
- cycle_cnt_o  out  CYC_W  count of cycles with ce_o=1

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset (async assert, sync deassert by the upstream reset sync):
  - START_RUNNING=1: state RUN, ce_o=1.
  - START_RUNNING=0: state STOPPED, ce_o=0.
  - steps_left_o=0, stop_cause_o=00, stop_evt_o=0, cmd_err_o=0, cycle_cnt_o=0.
- Latency: a command or trigger sampled at edge t changes ce_o at edge t (visible in the following cycle). The gate then passes or blocks the next rising edge.
- One emulated cycle is defined as one clk_i cycle with ce_o=1.
- STOPPED:
  - RUN -> RUN, ce_o<=1.
  - STEP with N>0 -> STEP, ce_o<=1, steps_left<=N.
  - STEP with N=0 -> stay STOPPED, no event.
  - STOP -> no-op.
  - trig_stop_i is ignored.
- RUN:
  - STOP -> STOPPED, ce_o<=0, cause 01.
  - trig_stop_i -> STOPPED, ce_o<=0, cause 10.
  - RUN -> no-op.
  - STEP -> ignored, cmd_err_o pulse.
- STEP:
  - Each cycle with ce_o=1, steps_left decrements.
  - When steps_left==1 at the sampling edge -> STOPPED, ce_o<=0, steps_left<=0, cause 11.
  - Result: ce_o is high for exactly N consecutive cycles.
  - STOP -> STOPPED, steps_left<=0, cause 01.
  - trig_stop_i -> STOPPED, steps_left<=0, cause 10.
  - RUN -> RUN, steps_left<=0.
  - STEP -> ignored, cmd_err_o pulse.
- Priority within one cycle: trig_stop_i > step completion > host command.
  - Trigger and STOP together: cause 10.
  - Last step and trigger together: cause 10.
- stop_cause_o holds until the next entry to STOPPED. RUN and STEP entry do not clear it.
- stop_evt_o pulses in the cycle after the transition into STOPPED, aligned with ce_o falling.
- N = 2^STEP_W-1 is legal; no wrap of steps_left.
- A reset mid-STEP aborts the step and applies the reset values.

Optional Feature:
- Macro: LOOM_CLK_CTRL_CYCLE_CNT_EN
- Defined: cycle_cnt_o increments by 1 on every cycle with ce_o=1 and wraps modulo 2^CYC_W. The cycle_cnt_o port is unaffected by commands; only reset clears it.
- Undefined: the counter is not instantiated and cycle_cnt_o is tied to 0. All other behaviour is identical.

Test Plan:
- Reset with START_RUNNING=1, release -> ce_o=1, state_o=01, stop_cause_o=00, no stop_evt_o.
- In RUN, STOP at cycle 10 -> ce_o=0 from cycle 11, state_o=00, stop_cause_o=01, single stop_evt_o pulse; with the macro, cycle_cnt_o frozen.
- From STOPPED, STEP N=5 -> ce_o high for exactly 5 cycles, steps_left_o 5,4,3,2,1 then 0, cause 11, one stop_evt_o; STEP N=0 -> no ce_o pulse, no event.
- STEP N=100, trig_stop_i on the 3rd enabled cycle -> ce_o high exactly 3 cycles, steps_left_o=0, cause 10.
- Same-cycle trig_stop_i and cmd STOP in RUN -> cause 10; STEP issued in RUN -> cmd_err_o single pulse, ce_o stays 1.
- Macro defined, CYC_W=4, RUN for 17 cycles -> cycle_cnt_o wraps to 1; assert rst_ni low mid-STEP -> ce_o immediately at reset value, steps_left_o=0.
